multdiv_unit: RTL and testbench
===============================

# multdiv_unit

Iterative signed 32-bit multiply/divide unit. It sits beside the single-cycle ALU (add/sub/bitwise/shift) in the execute stage: it takes the same two operand buses and delivers a registered result plus an exception flag to the writeback mux. It uses a one-bit-per-cycle datapath: shift-add for multiply, restoring subtract for divide. Latency is a fixed 33 cycles.

## Interface
- `WIDTH`, 32, operand and result width. Only 32 is supported; the counter is sized `$clog2(WIDTH)+1`.

- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `ctrl_MULT` input 1: single-cycle start pulse for multiply.
- `ctrl_DIV` input 1: single-cycle start pulse for divide.
- `data_operandA` input 32: multiplicand or dividend, two's complement. Sampled only on a start edge.
- `data_operandB` input 32: multiplier or divisor, two's complement. Sampled only on a start edge.
- `data_result` output 32: registered result. Holds its value until the next completion.
- `data_exception` output 1: registered exception flag. Updates together with `data_result`.
- `data_resultRDY` output 1: one-cycle completion pulse.

## Operation
- States: IDLE, MULT, DIV, DONE.
- Start:
  - A start edge is any rising edge where `ctrl_MULT` or `ctrl_DIV` is 1, in any state (including MULT, DIV or DONE).
  - On a start edge, latch both operands and the operation, clear the counter, and enter MULT or DIV.
  - If both ctrl lines are high on the same edge, MULT wins.
  - A start edge during MULT or DIV aborts the running operation. It produces no result and no pulse.
- MULT:
  - Convert operands to magnitudes and record the result sign as A[31]^B[31].
  - Run 32 shift-add iterations into a 64-bit product register.
  - Apply the sign at completion.
  - `data_result` = low 32 bits of the signed product.
  - `data_exception` = 1 when the 64-bit signed product is not the sign-extension of its low 32 bits.
- DIV:
  - Divide magnitudes by 32 restoring iterations; the quotient truncates toward zero.
  - Quotient sign = A[31]^B[31]. The remainder is discarded.
  - Divisor 0: result 0x00000000, exception 1.
  - A=0x80000000 with B=0xFFFFFFFF: result 0x80000000, exception 1.
  - Both special cases still take the full 33-cycle latency.
- Counter: counts 0..31 in MULT/DIV, one iteration per edge. The edge after count 31 enters DONE.
- DONE: lasts one cycle. `data_result` and `data_exception` are written on the edge entering DONE. The next edge returns to IDLE unless it is a start edge.
- Reset (`reset_n`=0, at any time, including mid-operation):
  - state IDLE, counter 0.
  - `data_result` 0x00000000, `data_exception` 0, `data_resultRDY` 0.
  - The in-flight operation is lost.

## Timing
- Start edge = E0. Iteration edges are E1..E32. E33 enters DONE.
- `data_resultRDY` is high during the cycle after E33 only: exactly one cycle.
- `data_result` and `data_exception` are valid from E33 and stable until the next completion or reset.
- A start edge coinciding with E33 (pulse cycle):
  - The completing result is still written and the pulse still fires.
  - The new operation begins; its E0 is that same edge.
- Operand changes after E0 have no effect.
- ctrl lines held high for multiple cycles are a restart on each edge. Callers pulse them for one cycle only.

## Test plan
- MULT, A=7, B=0xFFFFFFFD (-3) -> `data_result`=0xFFFFFFEB, exception 0, RDY high exactly in the cycle after E33, low elsewhere.
- MULT, A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1. MULT, A=0x80000000, B=1 -> result 0x80000000, exception 0.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> result 0xFFFFFFFD, exception 0. DIV, A=100, B=7 -> 0x0000000E.
- DIV, A=5, B=0 -> result 0, exception 1, after 33 cycles. DIV, A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1.
- Restart and priority:
  - MULT 3*4 started, then ctrl_DIV (A=20, B=5) pulsed at E10 -> no pulse for the MULT; one pulse 33 edges after the DIV start; result 4.
  - Both ctrl lines high on one edge -> MULT executed.
- Reset mid-operation:
  - `reset_n` low at E15 of a MULT -> outputs 0 immediately (asynchronous), no pulse afterwards.
  - A new DIV after reset release completes normally.

Source files
------------

// File: rtl/multdiv_unit_if.sv
// multdiv_unit_if: operand, start and result signals between the
// execute stage and the iterative multiply/divide unit.
interface multdiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;

   modport master (
      output ctrl_MULT, ctrl_DIV,
      output data_operandA, data_operandB,
      input  data_result, data_exception, data_resultRDY
   );

   modport slave (
      input  ctrl_MULT, ctrl_DIV,
      input  data_operandA, data_operandB,
      output data_result, data_exception, data_resultRDY
   );
endinterface

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed 32-bit multiply/divide,
// one bit per cycle, fixed 33-cycle latency from the start edge.
module multdiv_unit #(
   parameter int WIDTH = 32
) (
   input logic           clock,
   input logic           reset_n,
   multdiv_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] a_q, a_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               neg_q, neg_d;
   logic               dz_q, dz_d;
   logic               ovf_q, ovf_d;
   logic               exc_q, exc_d;
   logic               rdy_q, rdy_d;

   logic               start;
   logic               last;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     rem_sh, rem_sub;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot;

   // state, datapath and result registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         res_q   <= '0;
         neg_q   <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
         exc_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         res_q   <= res_d;
         neg_q   <= neg_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
         exc_q   <= exc_d;
         rdy_q   <= rdy_d;
      end
   end

   // next state: iterate, complete, or (re)start on any ctrl pulse
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      acc_d   = acc_q;
      b_d     = b_q;
      res_d   = res_q;
      neg_d   = neg_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      exc_d   = exc_q;
      rdy_d   = 1'b0;

      start = bus.ctrl_MULT | bus.ctrl_DIV;
      last  = (cnt_q == CW'(WIDTH));
      mag_a = bus.data_operandA[WIDTH-1] ?
              -bus.data_operandA : bus.data_operandA;
      mag_b = bus.data_operandB[WIDTH-1] ?
              -bus.data_operandB : bus.data_operandB;

      // restoring step: remainder in acc, dividend/quotient in b
      rem_sh  = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, a_q[WIDTH-1:0]};
      prod    = neg_q ? -acc_q : acc_q;
      quot    = neg_q ? -b_q : b_q;

      unique case (state_q)
         MULT: begin
            if (last) begin
               res_d   = prod[WIDTH-1:0];
               exc_d   = prod[2*WIDTH-1:WIDTH] !=
                         {WIDTH{prod[WIDTH-1]}};
               rdy_d   = 1'b1;
               state_d = DONE;
            end else begin
               if (b_q[0]) acc_d = acc_q + a_q;
               a_d   = a_q << 1;
               b_d   = b_q >> 1;
               cnt_d = cnt_q + 1'b1;
            end
         end
         DIV: begin
            if (last) begin
               if (dz_q) begin
                  res_d = '0;
               end else if (ovf_q) begin
                  res_d = {1'b1, {(WIDTH-1){1'b0}}};
               end else begin
                  res_d = quot;
               end
               exc_d   = dz_q | ovf_q;
               rdy_d   = 1'b1;
               state_d = DONE;
            end else begin
               if (!rem_sub[WIDTH]) begin
                  acc_d = {{(WIDTH-1){1'b0}}, rem_sub};
                  b_d   = {b_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {{(WIDTH-1){1'b0}}, rem_sh};
                  b_d   = {b_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // a start aborts any running op; a completing result above
      // is kept because res/exc/rdy are not touched here
      if (start) begin
         cnt_d = '0;
         acc_d = '0;
         neg_d = bus.data_operandA[WIDTH-1] ^
                 bus.data_operandB[WIDTH-1];
         if (bus.ctrl_MULT) begin
            state_d = MULT;
            a_d     = {{WIDTH{1'b0}}, mag_a};
            b_d     = mag_b;
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
         end else begin
            state_d = DIV;
            a_d     = {{WIDTH{1'b0}}, mag_b};
            b_d     = mag_a;
            dz_d    = (bus.data_operandB == '0);
            ovf_d   = (bus.data_operandA ==
                       {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (bus.data_operandB == '1);
         end
      end
   end

   assign bus.data_result    = res_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed vectors for the iterative
// multiply/divide unit, checked with immediate assertions.
module tb_multdiv_unit;
   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   multdiv_unit_if #(.WIDTH(32)) bus ();

   multdiv_unit #(.WIDTH(32)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // drive a start pulse; returns #1 after its E0 edge
   task automatic start_op(input logic m, input logic d,
                           input logic [31:0] a,
                           input logic [31:0] b);
      bus.ctrl_MULT     = m;
      bus.ctrl_DIV      = d;
      bus.data_operandA = a;
      bus.data_operandB = b;
      @(posedge clk);
      #1;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
   endtask

   // from #1 after E0: no pulse E1..E32, pulse after E33, gone after E34
   task automatic wait_done(input string tag,
                            input logic [31:0] exp_res,
                            input logic exp_exc);
      int early;
      early = 0;
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk);
         #1;
         if (bus.data_resultRDY) early++;
      end
      check({tag, " early rdy"}, 32'(early), 32'd0);
      @(posedge clk);
      #1;
      check({tag, " rdy"}, 32'(bus.data_resultRDY), 32'd1);
      check({tag, " result"}, bus.data_result, exp_res);
      check({tag, " exc"}, 32'(bus.data_exception), 32'(exp_exc));
      @(posedge clk);
      #1;
      check({tag, " rdy off"}, 32'(bus.data_resultRDY), 32'd0);
      check({tag, " hold"}, bus.data_result, exp_res);
   endtask

   initial begin
      int seen;
      rst_n             = 1'b0;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset result", bus.data_result, 32'h0);
      check("reset exc", 32'(bus.data_exception), 32'd0);
      check("reset rdy", 32'(bus.data_resultRDY), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      wait_done("mul 7*-3", 32'hFFFF_FFEB, 1'b0);
      start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
      wait_done("mul ovf", 32'h0000_0000, 1'b1);
      start_op(1'b1, 1'b0, 32'h8000_0000, 32'd1);
      wait_done("mul min*1", 32'h8000_0000, 1'b0);
      start_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
      wait_done("mul -5*-6", 32'd30, 1'b0);

      start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_done("div -7/2", 32'hFFFF_FFFD, 1'b0);
      start_op(1'b0, 1'b1, 32'd100, 32'd7);
      wait_done("div 100/7", 32'h0000_000E, 1'b0);
      start_op(1'b0, 1'b1, 32'd5, 32'd0);
      wait_done("div by 0", 32'h0000_0000, 1'b1);
      start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div min/-1", 32'h8000_0000, 1'b1);

      // restart: DIV pulse at E10 of a MULT
      start_op(1'b1, 1'b0, 32'd3, 32'd4);
      repeat (9) @(posedge clk);
      #1;
      start_op(1'b0, 1'b1, 32'd20, 32'd5);
      wait_done("restart div", 32'd4, 1'b0);

      // both ctrl lines high: multiply wins
      start_op(1'b1, 1'b1, 32'd6, 32'd7);
      wait_done("both ctrl", 32'd42, 1'b0);

      // start on the completing edge E33
      start_op(1'b1, 1'b0, 32'd2, 32'd3);
      repeat (32) @(posedge clk);
      #1;
      start_op(1'b0, 1'b1, 32'd9, 32'd3);
      check("e33 rdy", 32'(bus.data_resultRDY), 32'd1);
      check("e33 result", bus.data_result, 32'd6);
      wait_done("e33 div", 32'd3, 1'b0);

      // asynchronous reset in the middle of a multiply
      start_op(1'b1, 1'b0, 32'd5, 32'd6);
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async result", bus.data_result, 32'h0);
      check("async exc", 32'(bus.data_exception), 32'd0);
      check("async rdy", 32'(bus.data_resultRDY), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.data_resultRDY) seen++;
      end
      check("post reset rdy", 32'(seen), 32'd0);
      check("post reset result", bus.data_result, 32'h0);
      start_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
      wait_done("div after rst", 32'hFFFF_FFF2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
